alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked ALU: the registered, multi-cycle successor of the team's 32-bit combinational 8-op ALU. It takes one operation per valid/ready transaction. It returns a registered result plus zero, carry and overflow flags. Logic ops, add, sub and compare finish in one cycle; left shift runs iteratively, one bit position per cycle. It sits between the datapath operand registers and the writeback stage and can stall either side.

## Interface
- WIDTH, 32, operand/result width in bits (≥4; power of two).
- SIGNED_SLT, 0, op 110 compares signed (1) or unsigned (0).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept this cycle.
- alu_op  in  3  operation code.
- a  in  WIDTH  operand A (shift amount for op 111).
- b  in  WIDTH  operand B (shifted value for op 111).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- f  out  WIDTH  result.
- zf  out  1  f == 0.
- cf  out  1  carry (add) / borrow (sub), else 0.
- of  out  1  signed overflow (add/sub), else 0.

## Operation
- Ops:
  - 000 a&b
  - 001 a|b
  - 010 a^b
  - 011 ~(a^b)
  - 100 a+b
  - 101 a−b
  - 110 a<b ? 1 : 0, zero-extended; signedness set by SIGNED_SLT
  - 111 b<<a
- Width rules for add/sub:
  - Add: {cf,f} = a+b, computed WIDTH+1 wide.
  - Sub: f = a−b mod 2^WIDTH; cf = 1 iff a<b unsigned.
- Overflow:
  - Add: of = (a[MSB]==b[MSB]) && (f[MSB]!=a[MSB]).
  - Sub: of = (a[MSB]!=b[MSB]) && (f[MSB]!=a[MSB]).
- zf is computed from final f for every op.
- Shift amount n = full unsigned a.
  - n = 0: f = b, 1 cycle.
  - n ≥ WIDTH: f = 0, 1 cycle.
  - 1 ≤ n < WIDTH: iterative, one position per cycle.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On accept, a single-cycle op, or a shift with n=0 or n≥WIDTH, loads f/flags and goes to DONE.
  - IDLE, shift with 1 ≤ n < WIDTH: loads work=b<<1 and cnt=n−1. Goes to DONE if cnt==0, else to SHIFT.
  - SHIFT: in_ready=0. Each cycle work<<=1 and cnt−−. On the cycle cnt reaches 0, f=work and the FSM goes to DONE.
  - DONE: out_valid=1. If out_ready=0, hold f/flags stable and keep in_ready=0.
  - DONE with out_ready=1: in_ready=1 (back-to-back). A simultaneous accept loads the new op exactly as from IDLE. Otherwise go to IDLE.
- Undefined states return to IDLE.
- Inputs are ignored whenever in_ready=0. Operands are captured at accept, so a/b/alu_op may change afterwards.
- Reset (asynchronous assert, any state):
  - state=IDLE, f=0, zf=0, cf=0, of=0, out_valid=0, cnt=0.
  - An in-flight shift is discarded.
  - in_ready=1 from the first cycle after deassertion.

## Timing
- Accept at edge k.
- Single-cycle ops and degenerate shifts: out_valid high after edge k+1.
- Shift with 1 ≤ n < WIDTH: out_valid high after edge k+n.
- Max latency WIDTH−1 cycles.
- Throughput with out_ready held 1: one single-cycle op per clock. Shifts block for n cycles.
- in_ready is combinational from state and out_ready. No combinational path from a/b/alu_op to any output.
- out_valid, f and flags are registered. They change only on an accept-completion edge or on reset.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-shift (op 111, a=10).
  - Required: out_valid=0 and f=0 immediately. in_ready=1 after release. Next op 100, a=1, b=2 gives f=3 one cycle after accept.
- Add/sub flags, WIDTH=32:
  - 100, a=7FFF_FFFF, b=1 → f=8000_0000, of=1, cf=0, zf=0.
  - 100, a=FFFF_FFFF, b=1 → f=0, zf=1, cf=1, of=0.
  - 101, a=0, b=1 → f=FFFF_FFFF, cf=1, of=0.
- Shift latency:
  - 111, b=1, a=5 → out_valid exactly 5 cycles after accept, f=0000_0020, in_ready=0 throughout.
  - 111, a=0, b=0x1234 → f=0x1234 after 1 cycle.
  - 111, a=40, b=1 → f=0, zf=1 after 1 cycle.
- Back-pressure:
  - out_ready=0 for 4 cycles after 000, a=F0, b=3C.
  - Required: f=0x30 held stable, in_ready=0. On out_ready=1, a new op is accepted in the same cycle and its result appears 1 cycle later.
- SLT mode:
  - a=FFFF_FFFF, b=1.
  - SIGNED_SLT=0 → f=0, zf=1. SIGNED_SLT=1 → f=1.
- Parameter sweep:
  - WIDTH=8, 100, a=0x80, b=0x80 → f=0, cf=1, of=1, zf=1.
  - WIDTH=8, 111, a=7, b=1 → f=0x80 after 7 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/compare ops, iterative left shift.
// Results and flags are registered and held until the consumer takes them.
module alu_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          SIGNED_SLT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zf,
    output logic             cf,
    output logic             of
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned MSB   = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_f, w_f_nxt;
    logic               r_zf, w_zf_nxt;
    logic               r_cf, w_cf_nxt;
    logic               r_of, w_of_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0]   r_work, w_work_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_lt;
    logic [WIDTH-1:0]   w_work_sh;
    logic [WIDTH-1:0]   w_ld_f;
    logic               w_ld_cf;
    logic               w_ld_of;
    logic               w_ld_iter;
    logic               w_take;

    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_lt      = SIGNED_SLT ? ($signed(a) < $signed(b)) : (a < b);
    assign w_work_sh = r_work << 1;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign out_valid = r_out_valid;
    assign f         = r_f;
    assign zf        = r_zf;
    assign cf        = r_cf;
    assign of        = r_of;

    // Result of the presented op as it would be loaded on accept
    always_comb begin
        w_ld_f    = '0;
        w_ld_cf   = 1'b0;
        w_ld_of   = 1'b0;
        w_ld_iter = 1'b0;
        case (alu_op)
            3'b000: w_ld_f = a & b;
            3'b001: w_ld_f = a | b;
            3'b010: w_ld_f = a ^ b;
            3'b011: w_ld_f = ~(a ^ b);
            3'b100: begin
                w_ld_f  = w_sum[WIDTH-1:0];
                w_ld_cf = w_sum[WIDTH];
                w_ld_of = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            3'b101: begin
                w_ld_f  = w_diff[WIDTH-1:0];
                w_ld_cf = w_diff[WIDTH];
                w_ld_of = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            3'b110: w_ld_f = {{(WIDTH-1){1'b0}}, w_lt};
            3'b111: begin
                if (a == '0) begin
                    w_ld_f = b;
                end else if (a >= WIDTH'(WIDTH)) begin
                    w_ld_f = '0;
                end else begin
                    // n == 1 finishes on the accept edge; larger n iterates
                    w_ld_f    = b << 1;
                    w_ld_iter = (a != WIDTH'(1));
                end
            end
        endcase
    end

    // Next-state and result-register logic
    always_comb begin
        w_state_nxt = r_state;
        w_f_nxt     = r_f;
        w_zf_nxt    = r_zf;
        w_cf_nxt    = r_cf;
        w_of_nxt    = r_of;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        case (r_state)
            IDLE: w_take = in_valid;
            SHIFT: begin
                w_work_nxt = w_work_sh;
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_f_nxt     = w_work_sh;
                    w_zf_nxt    = (w_work_sh == '0);
                    w_cf_nxt    = 1'b0;
                    w_of_nxt    = 1'b0;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_take) begin
            if (w_ld_iter) begin
                w_state_nxt = SHIFT;
                w_work_nxt  = b << 1;
                w_cnt_nxt   = CNT_W'(a - WIDTH'(1));
            end else begin
                w_state_nxt = DONE;
                w_f_nxt     = w_ld_f;
                w_zf_nxt    = (w_ld_f == '0);
                w_cf_nxt    = w_ld_cf;
                w_of_nxt    = w_ld_of;
            end
        end
        w_out_valid_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_f         <= '0;
            r_zf        <= 1'b0;
            r_cf        <= 1'b0;
            r_of        <= 1'b0;
            r_out_valid <= 1'b0;
            r_work      <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_f         <= w_f_nxt;
            r_zf        <= w_zf_nxt;
            r_cf        <= w_cf_nxt;
            r_of        <= w_of_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_work      <= w_work_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (32-bit unsigned SLT, 32-bit signed SLT, 8-bit),
// directed vector table, handshake corner sequences and a randomized model check.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  vld;
    logic [2:0]  op_r;
    logic [31:0] a_r, b_r;
    logic        out_rdy;
    logic [2:0]  ir, ov, zo, co, oo;
    logic [31:0] fo [3];
    logic [31:0] f0, f1;
    logic [7:0]  f8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .SIGNED_SLT(1'b0)) u_u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(ir[0]), .alu_op(op_r),
        .a(a_r), .b(b_r), .out_valid(ov[0]), .out_ready(out_rdy), .f(f0),
        .zf(zo[0]), .cf(co[0]), .of(oo[0]));

    alu_seq #(.WIDTH(32), .SIGNED_SLT(1'b1)) u_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(ir[1]), .alu_op(op_r),
        .a(a_r), .b(b_r), .out_valid(ov[1]), .out_ready(out_rdy), .f(f1),
        .zf(zo[1]), .cf(co[1]), .of(oo[1]));

    alu_seq #(.WIDTH(8), .SIGNED_SLT(1'b0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(ir[2]), .alu_op(op_r),
        .a(a_r[7:0]), .b(b_r[7:0]), .out_valid(ov[2]), .out_ready(out_rdy), .f(f8),
        .zf(zo[2]), .cf(co[2]), .of(oo[2]));

    assign fo[0] = f0;
    assign fo[1] = f1;
    assign fo[2] = {24'd0, f8};

    typedef struct {
        logic [31:0] f;
        bit          z;
        bit          c;
        bit          o;
        int          lat;
    } res_t;

    typedef struct {
        int          s;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        res_t        e;
    } vec_t;

    function automatic int wid(input int s);
        return (s == 2) ? 8 : 32;
    endfunction

    // Reference: plain integer arithmetic on the mathematical values
    function automatic res_t model(input int s, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        res_t x;
        int w = wid(s);
        longint unsigned m    = (64'd1 << w) - 64'd1;
        longint unsigned half = 64'd1 << (w - 1);
        longint unsigned ua   = {32'd0, a} & m;
        longint unsigned ub   = {32'd0, b} & m;
        longint unsigned r;
        longint sa, sb, t;
        sa = (ua >= half) ? longint'(ua) - longint'(m + 64'd1) : longint'(ua);
        sb = (ub >= half) ? longint'(ub) - longint'(m + 64'd1) : longint'(ub);
        x.c = 1'b0; x.o = 1'b0; x.lat = 1;
        case (op)
            3'd0: r = ua & ub;
            3'd1: r = ua | ub;
            3'd2: r = ua ^ ub;
            3'd3: r = ~(ua ^ ub) & m;
            3'd4: begin
                r   = ua + ub;
                x.c = (r > m);
                r   = r & m;
                t   = sa + sb;
                x.o = (t > longint'(half) - 1) || (t < -longint'(half));
            end
            3'd5: begin
                r   = (ua - ub) & m;
                x.c = (ua < ub);
                t   = sa - sb;
                x.o = (t > longint'(half) - 1) || (t < -longint'(half));
            end
            3'd6: r = ((s == 1) ? (sa < sb) : (ua < ub)) ? 64'd1 : 64'd0;
            default: begin
                if (ua == 64'd0) begin
                    r = ub;
                end else if (ua >= longint'(w)) begin
                    r = 64'd0;
                end else begin
                    r     = (ub << ua) & m;
                    x.lat = int'(ua);
                end
            end
        endcase
        x.f = 32'(r);
        x.z = (r == 64'd0);
        return x;
    endfunction

    function automatic vec_t mk(input int s, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] f, input bit z,
                                input bit c, input bit o, input int lat);
        vec_t v;
        v.s = s; v.op = op; v.a = a; v.b = b;
        v.e.f = f; v.e.z = z; v.e.c = c; v.e.o = o; v.e.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // One transaction on instance s; hold = cycles out_ready stays low after the result
    task automatic run(input int s, input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input int hold,
                       output res_t g, output bit acc_ok, output bit stall_ok);
        int n;
        op_r = op; a_r = av; b_r = bv; out_rdy = 1'b1; vld[s] = 1'b1;
        #1;
        acc_ok = ir[s];
        n = 0;
        while (!ir[s] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        @(negedge clk);
        vld = '0;
        out_rdy = (hold == 0);
        #1;
        stall_ok = 1'b1;
        g.lat = 1;
        while (!ov[s] && g.lat < 100) begin
            if (ir[s]) stall_ok = 1'b0;
            @(negedge clk); #1;
            g.lat++;
        end
        g.f = fo[s]; g.z = zo[s]; g.c = co[s]; g.o = oo[s];
        if (hold > 0) begin
            if (ir[s]) stall_ok = 1'b0;
            repeat (hold) begin
                @(negedge clk); #1;
                if (ir[s] || !ov[s] || fo[s] !== g.f) stall_ok = 1'b0;
            end
        end
        out_rdy = 1'b1;
    endtask

    task automatic check_op(input string nm, input int s, input logic [2:0] op,
                            input logic [31:0] av, input logic [31:0] bv,
                            input int hold, input res_t e);
        res_t g;
        bit   acc_ok, stall_ok;
        run(s, op, av, bv, hold, g, acc_ok, stall_ok);
        chkb({nm, ".accept"}, acc_ok, 1'b1);
        chk({nm, ".f"}, g.f, e.f);
        chkb({nm, ".zf"}, g.z, e.z);
        chkb({nm, ".cf"}, g.c, e.c);
        chkb({nm, ".of"}, g.o, e.o);
        chk({nm, ".lat"}, 32'(g.lat), 32'(e.lat));
        if (hold > 0 || e.lat > 1) chkb({nm, ".stall"}, stall_ok, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        res_t        e;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          rs, rh, w;

        vld = '0; op_r = '0; a_r = '0; b_r = '0; out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.out_valid", {29'd0, ov}, 32'd0);
        chk("reset.f", fo[0], 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", {29'd0, ir}, 32'h7);

        vecs.push_back(mk(0, 3'd4, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 3'd5, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 1, 0, 1));
        vecs.push_back(mk(0, 3'd7, 32'd5, 32'h1, 32'h20, 0, 0, 0, 5));
        vecs.push_back(mk(0, 3'd7, 32'd0, 32'h1234, 32'h1234, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'd7, 32'd40, 32'h1, 32'h0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 3'd7, 32'd32, 32'hFFFF, 32'h0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 3'd7, 32'd31, 32'h1, 32'h8000_0000, 0, 0, 0, 31));
        vecs.push_back(mk(0, 3'd7, 32'd1, 32'h3, 32'h6, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'd1, 32'hA0, 32'h0B, 32'hAB, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'd2, 32'hFF, 32'h0F, 32'hF0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 3'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 1));
        vecs.push_back(mk(2, 3'd4, 32'h80, 32'h80, 32'h0, 1, 1, 1, 1));
        vecs.push_back(mk(2, 3'd5, 32'h80, 32'h01, 32'h7F, 0, 0, 1, 1));
        vecs.push_back(mk(2, 3'd7, 32'd7, 32'h1, 32'h80, 0, 0, 0, 7));
        vecs.push_back(mk(2, 3'd7, 32'd8, 32'h1, 32'h0, 1, 0, 0, 1));

        foreach (vecs[i])
            check_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].b,
                     0, vecs[i].e);

        // Back-pressure, then a new op accepted on the release cycle
        check_op("bp.and", 0, 3'd0, 32'hF0, 32'h3C, 4, mk(0, 0, 0, 0, 32'h30, 0, 0, 0, 1).e);
        check_op("bp.next", 0, 3'd4, 32'h1, 32'h1, 0, mk(0, 0, 0, 0, 32'h2, 0, 0, 0, 1).e);

        // Reset in the middle of a shift
        op_r = 3'd7; a_r = 32'd10; b_r = 32'h1; vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = '0;
        repeat (3) @(negedge clk);
        #1;
        chkb("midshift.in_ready", ir[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chkb("midshift.rst.out_valid", ov[0], 1'b0);
        chk("midshift.rst.f", fo[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chkb("midshift.release.in_ready", ir[0], 1'b1);
        check_op("after_rst.add", 0, 3'd4, 32'h1, 32'h2, 0, mk(0, 0, 0, 0, 32'h3, 0, 0, 0, 1).e);

        // Randomized ops against the reference model
        for (int i = 0; i < 240; i++) begin
            rs  = $urandom_range(0, 2);
            w   = wid(rs);
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (rop == 3'd7) begin
                case ($urandom_range(0, 3))
                    0: ra = 32'd0;
                    1: ra = 32'($urandom_range(1, w - 1));
                    2: ra = 32'(w);
                    default: ra = $urandom;
                endcase
            end else if ($urandom_range(0, 3) == 0) begin
                ra = (w == 8) ? 32'h80 : 32'h8000_0000;
                rb = $urandom_range(0, 1) ? ra : 32'hFFFF_FFFF;
            end
            rh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            e  = model(rs, rop, ra, rb);
            check_op($sformatf("rnd%0d", i), rs, rop, ra, rb, rh, e);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
